pickup_train_station: RTL and testbench



---
 rtl/pickup_train_station.sv | 175 +++++++++++++++++
 tb/tb_pickup_train_station.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pickup_train_station.sv
// pickup_train_station
//   Provider-side stop controller. Derives the train limit from stock on hand and
//   global demand (decreases are immediate, increases must persist for HOLD ticks),
//   publishes the supply percentage scaled by precision, and runs a dwell-time FSM
//   that raises an alarm and caps the limit when a parked train stalls.
// Ports
//   i_clk  tick clock, all state on rising edge
//   i_rst  synchronous active-high reset
//   i_u    buffer chest contents (units)
//   i_c    trains en route to or parked at this stop
//   i_t    nonzero while a train is parked
//   i_p    global precision
//   i_k    global demand (sum of dropoff limits)
//   o_l    train limit to stop (registered)
//   o_s    supply percentage scaled by i_p (registered)
//   o_x    stuck-train alarm (registered)
module pickup_train_station #(
  parameter int unsigned Q       = 3,
  parameter int unsigned M       = 128000,
  parameter int unsigned W       = 8000,
  parameter int unsigned HOLD    = 60,
  parameter int unsigned TIMEOUT = 1800,
  parameter int unsigned INT     = 31
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [INT:0] i_u,
  input  logic [INT:0] i_c,
  input  logic [INT:0] i_t,
  input  logic [INT:0] i_p,
  input  logic [INT:0] i_k,
  output logic [INT:0] o_l,
  output logic [INT:0] o_s,
  output logic         o_x
);

  localparam int unsigned DW = INT + 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_STUCK   = 2'd2;

  localparam logic [INT:0]      QW       = DW'(Q);
  localparam logic [INT:0]      WW       = DW'(W);
  localparam logic [INT:0]      HoldW    = DW'(HOLD);
  localparam logic [INT:0]      TimeoutW = DW'(TIMEOUT);
  localparam logic [2*DW-1:0]   MW       = (2*DW)'(M);

  logic [1:0]      r_state;
  logic [INT:0]    r_dwell;
  logic [INT:0]    r_hold;
  logic [INT:0]    r_tgt_prev;
  logic [INT:0]    r_l;
  logic [INT:0]    r_s;
  logic            r_x;

  logic [1:0]      w_state_d;
  logic [INT:0]    w_dwell_d;
  logic [INT:0]    w_dwell_inc;
  logic [INT:0]    w_hold_d;
  logic [INT:0]    w_hold_inc;
  logic [INT:0]    w_l_d;
  logic [INT:0]    w_ratio;
  logic [INT:0]    w_target;
  logic [2*DW-1:0] w_prod;
  logic [2*DW-1:0] w_quot;
  logic [INT:0]    w_s_d;

  // Target trains: none without demand, else whole loads on hand capped at Q.
  always_comb begin
    w_ratio  = i_u / WW;
    w_target = '0;
    if (i_k != '0) begin
      w_target = (w_ratio > QW) ? QW : w_ratio;
    end
  end

  // Supply percentage; the product is formed at double width so u*p cannot wrap.
  always_comb begin
    w_prod = {{DW{1'b0}}, i_u} * {{DW{1'b0}}, i_p};
    w_quot = w_prod / MW;
    w_s_d  = (w_quot > {{DW{1'b0}}, i_p}) ? i_p : w_quot[INT:0];
  end

  // Dwell FSM next state.
  always_comb begin
    w_state_d   = r_state;
    w_dwell_d   = r_dwell;
    w_dwell_inc = (r_dwell >= TimeoutW) ? TimeoutW : r_dwell + 1'b1;
    case (r_state)
      ST_EMPTY: begin
        w_dwell_d = '0;
        if (i_t != '0) begin
          w_dwell_d = {{INT{1'b0}}, 1'b1};
          w_state_d = (TIMEOUT <= 1) ? ST_STUCK : ST_LOADING;
        end
      end
      ST_LOADING: begin
        if (i_t == '0) begin
          w_state_d = ST_EMPTY;
          w_dwell_d = '0;
        end else begin
          w_dwell_d = w_dwell_inc;
          if (w_dwell_inc >= TimeoutW) begin
            w_state_d = ST_STUCK;
          end
        end
      end
      ST_STUCK: begin
        if (i_t == '0) begin
          w_state_d = ST_EMPTY;
          w_dwell_d = '0;
        end
      end
      default: begin
        w_state_d = ST_EMPTY;
        w_dwell_d = '0;
      end
    endcase
  end

  // Limit update. Forcing keys off the next state so the cap lands on the same
  // edge the alarm rises, and normal rules resume on the edge it falls.
  always_comb begin
    w_l_d      = r_l;
    w_hold_d   = r_hold;
    w_hold_inc = {{INT{1'b0}}, 1'b1};
    if (w_state_d == ST_STUCK) begin
      w_hold_d = '0;
      if (i_c < w_l_d) w_l_d = i_c;
      if (w_target < w_l_d) w_l_d = w_target;
    end else if (w_target < r_l) begin
      w_l_d    = w_target;
      w_hold_d = '0;
    end else if (w_target > r_l) begin
      // A count only continues for a target identical to last tick's.
      if (r_hold != '0 && w_target == r_tgt_prev) begin
        w_hold_inc = r_hold + 1'b1;
      end
      if (w_hold_inc >= HoldW) begin
        w_l_d    = w_target;
        w_hold_d = '0;
      end else begin
        w_hold_d = w_hold_inc;
      end
    end else begin
      w_hold_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_dwell    <= '0;
      r_hold     <= '0;
      r_tgt_prev <= '0;
      r_l        <= '0;
      r_s        <= '0;
      r_x        <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_dwell    <= w_dwell_d;
      r_hold     <= w_hold_d;
      r_tgt_prev <= w_target;
      r_l        <= w_l_d;
      r_s        <= w_s_d;
      r_x        <= (w_state_d == ST_STUCK);
    end
  end

  assign o_l = r_l;
  assign o_s = r_s;
  assign o_x = r_x;

endmodule

// File: tb/tb_pickup_train_station.sv
// Directed self-checking bench for pickup_train_station (default parameters).
module tb_pickup_train_station;

  logic        clk;
  logic        rst;
  logic [31:0] u, c, t, p, k;
  logic [31:0] l, s;
  logic        x;

  int checks = 0;
  int errors = 0;

  pickup_train_station dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_u   (u),
    .i_c   (c),
    .i_t   (t),
    .i_p   (p),
    .i_k   (k),
    .o_l   (l),
    .o_s   (s),
    .o_x   (x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; outputs are then sampled 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; u = 32'd24000; k = 32'd5; p = 32'd10000; c = 32'd0; t = 32'd0;
    step(2);
    check("reset_l", l, 32'd0);
    check("reset_s", s, 32'd0);
    check("reset_x", {31'd0, x}, 32'd0);

    // Steady stock after release: s after 1 edge, l rises on the 60th edge.
    rst = 1'b0;
    step(1);
    check("s_first", s, 32'd1875);
    check("l_first", l, 32'd0);
    step(58);
    check("l_edge59", l, 32'd0);
    step(1);
    check("l_edge60", l, 32'd3);

    p = 32'd100;
    step(1);
    check("s_p100", s, 32'd18);
    p = 32'd10000;

    // Demand removal then restore.
    k = 32'd0;
    step(1);
    check("l_k0", l, 32'd0);
    k = 32'd5;
    step(59);
    check("l_krestore59", l, 32'd0);
    step(1);
    check("l_krestore60", l, 32'd3);

    // Immediate decreases.
    u = 32'd16000;
    step(1);
    check("l_dec2", l, 32'd2);
    u = 32'd8000;
    step(1);
    check("l_dec1", l, 32'd1);

    // Hysteresis restart: target toggles every 30 ticks, never persists 60.
    for (int ph = 0; ph < 5; ph++) begin
      u = (ph % 2 == 0) ? 32'd16000 : 32'd24000;
      for (int i = 0; i < 30; i++) begin
        step(1);
        check("l_hyst", l, 32'd1);
      end
    end
    u = 32'd24000;
    step(59);
    check("l_hyst_hold59", l, 32'd1);
    step(1);
    check("l_hyst_hold60", l, 32'd3);

    // Stuck train.
    c = 32'd2; t = 32'd1;
    step(1799);
    check("x_1799", {31'd0, x}, 32'd0);
    check("l_1799", l, 32'd3);
    step(1);
    check("x_1800", {31'd0, x}, 32'd1);
    check("l_stuck", l, 32'd2);
    step(5);
    check("l_stuck_hold", l, 32'd2);
    check("x_stuck_hold", {31'd0, x}, 32'd1);
    u = 32'd8000;
    step(1);
    check("l_stuck_dec", l, 32'd1);
    u = 32'd24000; t = 32'd0;
    step(1);
    check("x_clear", {31'd0, x}, 32'd0);
    check("l_after_clear", l, 32'd1);
    step(58);
    check("l_recover59", l, 32'd1);
    step(1);
    check("l_recover60", l, 32'd3);

    // Saturation and width of the percentage.
    u = 32'd200000; p = 32'd10000;
    step(1);
    check("s_sat", s, 32'd10000);
    u = 32'd128000;
    step(1);
    check("s_eq_m", s, 32'd10000);
    u = 32'd127999;
    step(1);
    check("s_below_m", s, 32'd9999);
    u = 32'd64000; p = 32'd100000;
    step(1);
    check("s_wide", s, 32'd50000);
    u = 32'd200000;
    step(1);
    check("s_wide_sat", s, 32'd100000);
    check("l_qcap", l, 32'd3);

    // Mid-operation reset: dwell 900 in LOADING, hold count 40.
    p = 32'd10000; u = 32'd8000;
    step(1);
    check("l_pre_rst", l, 32'd1);
    t = 32'd1;
    step(860);
    u = 32'd24000;
    step(40);
    check("l_hold40", l, 32'd1);
    check("x_dwell900", {31'd0, x}, 32'd0);
    rst = 1'b1;
    step(1);
    check("rst_mid_l", l, 32'd0);
    check("rst_mid_s", s, 32'd0);
    check("rst_mid_x", {31'd0, x}, 32'd0);
    rst = 1'b0;
    step(1);
    check("rst_rel_s", s, 32'd1875);
    step(58);
    check("rst_rel_l59", l, 32'd0);
    step(1);
    check("rst_rel_l60", l, 32'd3);
    step(1739);
    check("rst_x_1799", {31'd0, x}, 32'd0);
    step(1);
    check("rst_x_1800", {31'd0, x}, 32'd1);
    check("rst_l_stuck", l, 32'd2);
    t = 32'd0;
    step(1);
    check("rst_x_clear", {31'd0, x}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
